execute: RTL and testbench

//  EX stage of the 5-stage MIPS pipeline; consumes the ID/EX register driven by decode (operands, imm, rt/rd/rs/shamt, control buses).

---
 rtl/execute_pkg.sv | 51 +++++
 rtl/execute_alu.sv | 58 +++++
 rtl/execute.sv | 136 +++++++++++++
 tb/tb_execute.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// Shared encodings for the EX stage: control bus layout, ALU op codes, R-type funct codes.
package execute_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned FUNCT_W  = 6;

  typedef struct packed {
    logic [1:0]          reg_dst;
    logic                alu_src;
    logic                zero_ext;
    logic                link;
    logic                jump;
    logic                jr;
    logic [ALU_OP_W-1:0] alu_op;
  } exec_ctrl_t;

  localparam int unsigned EXEC_CTRL_W = $bits(exec_ctrl_t);

  localparam logic [1:0] REG_DST_RT  = 2'b00;
  localparam logic [1:0] REG_DST_RD  = 2'b01;
  localparam logic [1:0] REG_DST_R31 = 2'b10;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'h4;
  localparam logic [ALU_OP_W-1:0] ALU_NOR   = 4'h5;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'h6;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'h7;
  localparam logic [ALU_OP_W-1:0] ALU_LUI   = 4'h8;
  localparam logic [ALU_OP_W-1:0] ALU_RTYPE = 4'hF;

  localparam logic [FUNCT_W-1:0] FN_SLL  = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_SRL  = 6'h02;
  localparam logic [FUNCT_W-1:0] FN_SRA  = 6'h03;
  localparam logic [FUNCT_W-1:0] FN_SLLV = 6'h04;
  localparam logic [FUNCT_W-1:0] FN_SRLV = 6'h06;
  localparam logic [FUNCT_W-1:0] FN_SRAV = 6'h07;
  localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;
  localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_XOR  = 6'h26;
  localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;
  localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;
  localparam logic [FUNCT_W-1:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/execute_alu.sv
// Combinational EX-stage ALU: op-coded and R-type (funct) operations, plus operand equality.
module execute_alu
  import execute_pkg::*;
#(
  parameter int unsigned len = 32,
  parameter int unsigned NB  = 5
) (
  input  logic [len-1:0]      op_a,
  input  logic [len-1:0]      op_b,
  input  logic [NB-1:0]       shamt,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0]  funct,
  output logic [len-1:0]      result,
  output logic                zero
);

  logic [NB-1:0] var_sh;
  assign var_sh = op_a[NB-1:0];

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_XOR:  result = op_a ^ op_b;
      ALU_NOR:  result = ~(op_a | op_b);
      ALU_SLT:  result = len'($signed(op_a) < $signed(op_b));
      ALU_SLTU: result = len'(op_a < op_b);
      ALU_LUI:  result = op_b << 16;
      ALU_RTYPE: begin
        // Shifts act on rt (op_b); variable shifts take the amount from rs (op_a).
        case (funct)
          FN_SLL:           result = op_b << shamt;
          FN_SRL:           result = op_b >> shamt;
          FN_SRA:           result = len'($signed(op_b) >>> shamt);
          FN_SLLV:          result = op_b << var_sh;
          FN_SRLV:          result = op_b >> var_sh;
          FN_SRAV:          result = len'($signed(op_b) >>> var_sh);
          FN_ADD, FN_ADDU:  result = op_a + op_b;
          FN_SUB, FN_SUBU:  result = op_a - op_b;
          FN_AND:           result = op_a & op_b;
          FN_OR:            result = op_a | op_b;
          FN_XOR:           result = op_a ^ op_b;
          FN_NOR:           result = ~(op_a | op_b);
          FN_SLT:           result = len'($signed(op_a) < $signed(op_b));
          FN_SLTU:          result = len'(op_a < op_b);
          default:          result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

  assign zero = (op_a == op_b);

endmodule

// File: rtl/execute.sv
// EX stage: operand forwarding, ALU, destination select, branch target, EX/MEM register.
module execute
  import execute_pkg::*;
#(
  parameter int unsigned len          = 32,
  parameter int unsigned NB           = 5,
  parameter int unsigned len_exec_bus = 11,
  parameter int unsigned len_mem_bus  = 9,
  parameter int unsigned len_wb_bus   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [len-1:0]          in_pc_branch,
  input  logic [len-1:0]          in_reg1,
  input  logic [len-1:0]          in_reg2,
  input  logic [len-1:0]          in_sign_extend,
  input  logic [NB-1:0]           in_rt,
  input  logic [NB-1:0]           in_rd,
  input  logic [NB-1:0]           in_rs,
  input  logic [NB-1:0]           in_shamt,
  input  logic [len_exec_bus-1:0] execute_bus,
  input  logic [len_mem_bus-1:0]  memory_bus,
  input  logic [len_wb_bus-1:0]   writeBack_bus,
  input  logic                    flush,
  input  logic                    halt_flag_e,
  input  logic                    fwd_regwrite_m,
  input  logic [NB-1:0]           fwd_rd_m,
  input  logic [len-1:0]          fwd_data_m,
  input  logic                    fwd_regwrite_w,
  input  logic [NB-1:0]           fwd_rd_w,
  input  logic [len-1:0]          fwd_data_w,
  output logic [len-1:0]          out_alu_result,
  output logic [len-1:0]          out_store_data,
  output logic [NB-1:0]           out_write_register,
  output logic [len-1:0]          out_pc_branch,
  output logic                    out_zero,
  output logic [len_mem_bus-1:0]  out_memory_bus,
  output logic [len_wb_bus-1:0]   out_writeBack_bus,
  output logic                    out_halt_flag_e
);

  localparam logic [NB-1:0] REG_LINK = '1;

  exec_ctrl_t     ctrl;
  logic [len-1:0] op_a;
  logic [len-1:0] rt_val;
  logic [len-1:0] imm;
  logic [len-1:0] op_b;
  logic [len-1:0] alu_res;
  logic           alu_zero;
  logic [len-1:0] result;
  logic [NB-1:0]  dest;
  logic           unused_ctrl;

  assign ctrl        = execute_bus[EXEC_CTRL_W-1:0];
  assign unused_ctrl = ^{ctrl.jump, ctrl.jr};

  // EX/MEM has priority over MEM/WB; r0 is never forwarded.
  always_comb begin
    op_a = in_reg1;
    if (fwd_regwrite_m && (fwd_rd_m == in_rs) && (in_rs != '0))
      op_a = fwd_data_m;
    else if (fwd_regwrite_w && (fwd_rd_w == in_rs) && (in_rs != '0))
      op_a = fwd_data_w;
  end

  always_comb begin
    rt_val = in_reg2;
    if (fwd_regwrite_m && (fwd_rd_m == in_rt) && (in_rt != '0))
      rt_val = fwd_data_m;
    else if (fwd_regwrite_w && (fwd_rd_w == in_rt) && (in_rt != '0))
      rt_val = fwd_data_w;
  end

  assign imm  = ctrl.zero_ext ? {{(len-16){1'b0}}, in_sign_extend[15:0]} : in_sign_extend;
  assign op_b = ctrl.alu_src ? imm : rt_val;

  execute_alu #(.len(len), .NB(NB)) u_alu (
    .op_a   (op_a),
    .op_b   (op_b),
    .shamt  (in_shamt),
    .alu_op (ctrl.alu_op),
    .funct  (in_sign_extend[FUNCT_W-1:0]),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Link overrides both the result and the destination selection.
  always_comb begin
    result = alu_res;
    dest   = '0;
    case (ctrl.reg_dst)
      REG_DST_RT:  dest = in_rt;
      REG_DST_RD:  dest = in_rd;
      REG_DST_R31: dest = REG_LINK;
      default:     dest = '0;
    endcase
    if (ctrl.link) begin
      result = in_pc_branch;
      dest   = REG_LINK;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_alu_result     <= '0;
      out_store_data     <= '0;
      out_write_register <= '0;
      out_pc_branch      <= '0;
      out_zero           <= 1'b0;
      out_memory_bus     <= '0;
      out_writeBack_bus  <= '0;
      out_halt_flag_e    <= 1'b0;
    end else begin
      out_halt_flag_e <= halt_flag_e;
      if (flush) begin
        out_alu_result     <= '0;
        out_store_data     <= '0;
        out_write_register <= '0;
        out_pc_branch      <= '0;
        out_zero           <= 1'b0;
        out_memory_bus     <= '0;
        out_writeBack_bus  <= '0;
      end else begin
        out_alu_result     <= result;
        out_store_data     <= rt_val;
        out_write_register <= dest;
        out_pc_branch      <= in_pc_branch + (in_sign_extend << 2);
        out_zero           <= alu_zero;
        out_memory_bus     <= memory_bus;
        out_writeBack_bus  <= writeBack_bus;
      end
    end
  end

endmodule

// File: tb/tb_execute.sv
// Randomized and directed bench for the EX stage against a behavioural instruction-level model.
module tb_execute;

  typedef struct {
    logic [31:0] pc, reg1, reg2, se;
    logic [4:0]  rt, rd, rs, shamt;
    logic [10:0] ebus;
    logic [8:0]  mbus;
    logic [1:0]  wb;
    logic        flush, halt;
    logic        rw_m;
    logic [4:0]  rd_m;
    logic [31:0] data_m;
    logic        rw_w;
    logic [4:0]  rd_w;
    logic [31:0] data_w;
  } stim_t;

  typedef struct {
    logic [31:0] alu, store, pcb;
    logic [4:0]  wr;
    logic        zero, halt;
    logic [8:0]  mbus;
    logic [1:0]  wb;
  } exp_t;

  logic        clk, reset;
  logic [31:0] in_pc_branch, in_reg1, in_reg2, in_sign_extend;
  logic [4:0]  in_rt, in_rd, in_rs, in_shamt;
  logic [10:0] execute_bus;
  logic [8:0]  memory_bus;
  logic [1:0]  writeBack_bus;
  logic        flush, halt_flag_e;
  logic        fwd_regwrite_m, fwd_regwrite_w;
  logic [4:0]  fwd_rd_m, fwd_rd_w;
  logic [31:0] fwd_data_m, fwd_data_w;
  logic [31:0] out_alu_result, out_store_data, out_pc_branch;
  logic [4:0]  out_write_register;
  logic        out_zero, out_halt_flag_e;
  logic [8:0]  out_memory_bus;
  logic [1:0]  out_writeBack_bus;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_v;

  execute dut (
    .clk(clk), .reset(reset),
    .in_pc_branch(in_pc_branch), .in_reg1(in_reg1), .in_reg2(in_reg2),
    .in_sign_extend(in_sign_extend), .in_rt(in_rt), .in_rd(in_rd), .in_rs(in_rs),
    .in_shamt(in_shamt), .execute_bus(execute_bus), .memory_bus(memory_bus),
    .writeBack_bus(writeBack_bus), .flush(flush), .halt_flag_e(halt_flag_e),
    .fwd_regwrite_m(fwd_regwrite_m), .fwd_rd_m(fwd_rd_m), .fwd_data_m(fwd_data_m),
    .fwd_regwrite_w(fwd_regwrite_w), .fwd_rd_w(fwd_rd_w), .fwd_data_w(fwd_data_w),
    .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_write_register(out_write_register), .out_pc_branch(out_pc_branch),
    .out_zero(out_zero), .out_memory_bus(out_memory_bus),
    .out_writeBack_bus(out_writeBack_bus), .out_halt_flag_e(out_halt_flag_e)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [10:0] mk_ebus(input logic [1:0] regdst, input logic src,
                                          input logic zx, input logic lk, input logic [3:0] op);
    return {regdst, src, zx, lk, 2'b00, op};
  endfunction

  function automatic stim_t zero_stim();
    stim_t s;
    s.pc = 0; s.reg1 = 0; s.reg2 = 0; s.se = 0;
    s.rt = 0; s.rd = 0; s.rs = 0; s.shamt = 0;
    s.ebus = 0; s.mbus = 0; s.wb = 0; s.flush = 0; s.halt = 0;
    s.rw_m = 0; s.rd_m = 0; s.data_m = 0; s.rw_w = 0; s.rd_w = 0; s.data_w = 0;
    return s;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.alu = 0; e.store = 0; e.pcb = 0; e.wr = 0; e.zero = 0; e.halt = 0; e.mbus = 0; e.wb = 0;
    return e;
  endfunction

  // Value an instruction sees for register idx, given the two in-flight writers.
  function automatic logic [31:0] operand(input stim_t s, input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return rf;
    if (s.rw_m && s.rd_m == idx) return s.data_m;
    if (s.rw_w && s.rd_w == idx) return s.data_w;
    return rf;
  endfunction

  function automatic logic [31:0] shift_right_arith(input logic [31:0] v, input int n);
    logic [31:0] r = v;
    for (int i = 0; i < n; i++) r = {r[31], r[31:1]};
    return r;
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t        e;
    logic [31:0] a, rtv, imm, b, r;
    logic [5:0]  fn;
    int          ia, ib;
    e = zero_exp();
    e.halt = s.halt;
    if (s.flush) return e;
    a   = operand(s, s.rs, s.reg1);
    rtv = operand(s, s.rt, s.reg2);
    imm = s.ebus[7] ? (s.se & 32'h0000FFFF) : s.se;
    b   = s.ebus[8] ? imm : rtv;
    ia  = a; ib = b;
    fn  = s.se[5:0];
    r   = 0;
    case (s.ebus[3:0])
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ~(a | b);
      4'h6: r = (ia < ib) ? 1 : 0;
      4'h7: r = (a < b) ? 1 : 0;
      4'h8: r = b * 32'h10000;
      4'hF: begin
        case (fn)
          6'h00: r = b << s.shamt;
          6'h02: r = b >> s.shamt;
          6'h03: r = shift_right_arith(b, int'(s.shamt));
          6'h04: r = b << (a % 32);
          6'h06: r = b >> (a % 32);
          6'h07: r = shift_right_arith(b, int'(a % 32));
          6'h20, 6'h21: r = a + b;
          6'h22, 6'h23: r = a - b;
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h26: r = a ^ b;
          6'h27: r = ~(a | b);
          6'h2A: r = (ia < ib) ? 1 : 0;
          6'h2B: r = (a < b) ? 1 : 0;
          default: r = 0;
        endcase
      end
      default: r = 0;
    endcase
    case (s.ebus[10:9])
      2'b00: e.wr = s.rt;
      2'b01: e.wr = s.rd;
      default: e.wr = 5'd31;
    endcase
    if (s.ebus[6]) begin
      r    = s.pc;
      e.wr = 5'd31;
    end
    e.alu   = r;
    e.store = rtv;
    e.zero  = (a == b);
    e.pcb   = s.pc + s.se * 4;
    e.mbus  = s.mbus;
    e.wb    = s.wb;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, want, $time);
    end
  endtask

  task automatic compare_all();
    check("alu_result",     out_alu_result,            exp_v.alu);
    check("store_data",     out_store_data,            exp_v.store);
    check("write_register", 32'(out_write_register),   32'(exp_v.wr));
    check("pc_branch",      out_pc_branch,             exp_v.pcb);
    check("zero",           32'(out_zero),             32'(exp_v.zero));
    check("memory_bus",     32'(out_memory_bus),       32'(exp_v.mbus));
    check("writeback_bus",  32'(out_writeBack_bus),    32'(exp_v.wb));
    check("halt_flag",      32'(out_halt_flag_e),      32'(exp_v.halt));
  endtask

  task automatic apply(input stim_t s);
    in_pc_branch = s.pc; in_reg1 = s.reg1; in_reg2 = s.reg2; in_sign_extend = s.se;
    in_rt = s.rt; in_rd = s.rd; in_rs = s.rs; in_shamt = s.shamt;
    execute_bus = s.ebus; memory_bus = s.mbus; writeBack_bus = s.wb;
    flush = s.flush; halt_flag_e = s.halt;
    fwd_regwrite_m = s.rw_m; fwd_rd_m = s.rd_m; fwd_data_m = s.data_m;
    fwd_regwrite_w = s.rw_w; fwd_rd_w = s.rd_w; fwd_data_w = s.data_w;
  endtask

  // One instruction: present at negedge, capture model at posedge, compare at next negedge.
  task automatic step(input stim_t s);
    apply(s);
    @(posedge clk);
    exp_v = model(s);
    @(negedge clk);
    compare_all();
  endtask

  function automatic stim_t rand_stim();
    stim_t      s;
    logic [5:0] fn_tab [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22,
                                6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01, 6'h3F};
    logic [3:0] op;
    s = zero_stim();
    s.pc    = $urandom;
    s.reg1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    s.reg2  = $urandom;
    s.se    = $urandom;
    s.se[5:0] = fn_tab[$urandom_range(0, 17)];
    s.rt    = 5'($urandom_range(0, 3));
    s.rs    = 5'($urandom_range(0, 3));
    s.rd    = 5'($urandom_range(0, 31));
    s.shamt = 5'($urandom_range(0, 31));
    op      = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
    s.ebus  = mk_ebus(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0), op);
    s.ebus[5:4] = 2'($urandom_range(0, 3));
    s.mbus  = 9'($urandom);
    s.wb    = 2'($urandom);
    s.flush = ($urandom_range(0, 9) == 0);
    s.halt  = ($urandom_range(0, 7) == 0);
    s.rw_m  = 1'($urandom_range(0, 1));
    s.rd_m  = 5'($urandom_range(0, 3));
    s.data_m = $urandom;
    s.rw_w  = 1'($urandom_range(0, 1));
    s.rd_w  = 5'($urandom_range(0, 3));
    s.data_w = $urandom;
    return s;
  endfunction

  initial begin
    stim_t s;
    reset = 1'b0;
    apply(zero_stim());
    exp_v = zero_exp();
    #3;
    compare_all();
    @(negedge clk);
    reset = 1'b1;

    // R-type add without hazards
    s = zero_stim();
    s.reg1 = 5; s.reg2 = 7; s.rs = 1; s.rt = 2; s.rd = 3; s.se = 32'h20;
    s.ebus = mk_ebus(2'b01, 0, 0, 0, 4'hF); s.wb = 2'b10;
    step(s);
    check("lit_add_result", out_alu_result, 32'd12);
    check("lit_add_dest",   32'(out_write_register), 32'd3);
    check("lit_add_regwr",  32'(out_writeBack_bus[1]), 32'd1);

    // EX/MEM beats MEM/WB for the same register
    s = zero_stim();
    s.rs = 2; s.rt = 1; s.reg1 = 32'h99; s.reg2 = 1; s.rd = 4;
    s.rw_m = 1; s.rd_m = 2; s.data_m = 32'h10; s.rw_w = 1; s.rd_w = 2; s.data_w = 32'h20;
    s.ebus = mk_ebus(2'b01, 0, 0, 0, 4'h1);
    step(s);
    check("lit_fwd_prio", out_alu_result, 32'h0F);

    // r0 is never forwarded
    s.rs = 0; s.rd_m = 0; s.rd_w = 0; s.reg1 = 32'h55;
    step(s);
    check("lit_fwd_r0", out_alu_result, 32'h54);

    // sra by shamt, then srlv by rs[4:0]
    s = zero_stim();
    s.rt = 2; s.reg2 = 32'h80000000; s.shamt = 4; s.se = 32'h03;
    s.ebus = mk_ebus(2'b01, 0, 0, 0, 4'hF);
    step(s);
    check("lit_sra", out_alu_result, 32'hF8000000);
    s.se = 32'h06; s.rs = 1; s.reg1 = 32'h24; s.shamt = 0;
    step(s);
    check("lit_srlv", out_alu_result, 32'h08000000);

    // Backward branch target with equal operands
    s = zero_stim();
    s.pc = 32'h100; s.se = 32'hFFFFFFFF; s.rs = 1; s.rt = 2; s.reg1 = 9; s.reg2 = 9;
    s.ebus = mk_ebus(2'b00, 0, 0, 0, 4'h1);
    step(s);
    check("lit_br_target", out_pc_branch, 32'hFC);
    check("lit_br_zero",   32'(out_zero), 32'd1);

    // jal: link value and r31 regardless of RegDst
    s = zero_stim();
    s.pc = 32'h40; s.rd = 7; s.ebus = mk_ebus(2'b01, 0, 0, 1, 4'h0); s.wb = 2'b10;
    step(s);
    check("lit_jal_result", out_alu_result, 32'h40);
    check("lit_jal_dest",   32'(out_write_register), 32'd31);

    // Flush squashes a valid add but still passes the halt marker
    s = zero_stim();
    s.reg1 = 5; s.reg2 = 7; s.rs = 1; s.rt = 2; s.rd = 3; s.se = 32'h20; s.pc = 32'h80;
    s.ebus = mk_ebus(2'b01, 0, 0, 0, 4'hF); s.wb = 2'b10; s.mbus = 9'h1FF;
    s.flush = 1; s.halt = 1;
    step(s);
    check("lit_flush_result", out_alu_result, 32'd0);
    check("lit_flush_wb",     32'(out_writeBack_bus), 32'd0);
    check("lit_flush_halt",   32'(out_halt_flag_e), 32'd1);

    // Asynchronous reset mid-cycle clears live outputs without a clock edge
    s.flush = 0; s.halt = 0;
    step(s);
    #2;
    reset = 1'b0;
    #1;
    exp_v = zero_exp();
    compare_all();
    check("lit_async_reset", out_alu_result, 32'd0);
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 400; i++) step(rand_stim());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
